// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory responder: FSM encoding, default widths,
// the default I/O register address and the wait-counter width.
package mem_if_pkg;

  localparam int          DATA_W_DEF    = 16;
  localparam logic [15:0] MMIO_ADDR_DEF = 16'hFFFF;
  localparam int          CNT_W         = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // A word address is backed by SRAM only if every bit above the index is zero.
  function automatic logic addr_in_range(input logic [15:0] a, input int aw);
    return (a >> aw) == 16'd0;
  endfunction

endpackage

// File: rtl/mem_sram_array.sv
// Single-port word SRAM: synchronous write, registered read. Contents are
// never cleared; the read register only updates when a read is enabled.
module mem_sram_array
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches one request, waits WAIT_CYCLES, accesses the
// SRAM, then pulses Ready. Optional I/O register when MMIO_LOAD_STORE_EN is defined.
//
// Handshake: Req/MemWrite/Addr/WriteData are sampled only on the edge where the
// FSM is IDLE and Req=1; later input changes are ignored until IDLE again.
// Ready is a single-cycle pulse with ReadData/AddrFault valid alongside it;
// ReadData then holds until the next read response.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int          DATA_W      = DATA_W_DEF,
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] MMIO_ADDR   = MMIO_ADDR_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Req,
  input  logic              MemWrite,
  input  logic [15:0]       Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Ready,
  output logic              Busy,
  output logic              AddrFault,
`ifdef MMIO_LOAD_STORE_EN
  output logic [DATA_W-1:0] IoOut,
  input  logic [DATA_W-1:0] IoIn,
`endif
  output logic [1:0]        o_dbg_state
);

`ifdef MMIO_LOAD_STORE_EN
  localparam logic MMIO_DECODE = 1'b1;
`else
  localparam logic MMIO_DECODE = 1'b0;
`endif

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_read_data;
  logic              r_ready;
  logic              r_fault;
`ifdef MMIO_LOAD_STORE_EN
  logic [DATA_W-1:0] r_io_out;
  logic [DATA_W-1:0] r_io_smp;
`endif

  logic              w_is_mmio;
  logic              w_in_range;
  logic              w_access;
  logic              w_sram_we;
  logic              w_sram_re;
  logic [DATA_W-1:0] w_sram_rdata;

  // The I/O address wins over the range check; in the default build it is ordinary.
  assign w_is_mmio  = MMIO_DECODE && (r_addr == MMIO_ADDR);
  assign w_in_range = addr_in_range(r_addr, ADDR_W);
  assign w_access   = (r_state == ST_ACCESS);
  assign w_sram_we  = w_access && r_we && w_in_range && !w_is_mmio;
  assign w_sram_re  = w_access && !r_we && w_in_range && !w_is_mmio;

  mem_sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_sram (
    .i_clk   (CLK),
    .i_we    (w_sram_we),
    .i_re    (w_sram_re),
    .i_addr  (r_addr[ADDR_W-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_sram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
`ifdef MMIO_LOAD_STORE_EN
      r_io_out    <= '0;
      r_io_smp    <= '0;
`endif
    end else begin
      r_ready <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Req) begin
            r_addr  <= Addr;
            r_we    <= MemWrite;
            r_wdata <= WriteData;
            if (WAIT_CYCLES == 0) begin
              r_state <= ST_ACCESS;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_W'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
`ifdef MMIO_LOAD_STORE_EN
          if (w_is_mmio) begin
            if (r_we) r_io_out <= r_wdata;
            else      r_io_smp <= IoIn;
          end
`endif
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          // Response registers update here, so the pulse lands in the following cycle.
          r_ready <= 1'b1;
          r_fault <= !w_in_range && !w_is_mmio;
          if (!r_we) begin
`ifdef MMIO_LOAD_STORE_EN
            if (w_is_mmio)       r_read_data <= r_io_smp;
            else if (w_in_range) r_read_data <= w_sram_rdata;
            else                 r_read_data <= '0;
`else
            if (w_in_range) r_read_data <= w_sram_rdata;
            else            r_read_data <= '0;
`endif
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ReadData    = r_read_data;
  assign Ready       = r_ready;
  assign Busy        = (r_state != ST_IDLE);
  assign AddrFault   = r_fault;
  assign o_dbg_state = r_state;
`ifdef MMIO_LOAD_STORE_EN
  assign IoOut = r_io_out;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 1, 0, 3) checked every
// cycle against a transaction-timing model, plus directed literal scenarios.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int NI = 3;
  localparam int AW = 10;
`ifdef MMIO_LOAD_STORE_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic logic in_range(input logic [15:0] a);
    return int'(a) < (1 << AW);
  endfunction

  function automatic logic is_mmio(input logic [15:0] a);
    return MMIO_ON && (a == 16'hFFFF);
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic        req  [NI];
  logic        mw   [NI];
  logic [15:0] addr [NI];
  logic [15:0] wd   [NI];
  logic [15:0] rd   [NI];
  logic        rdy  [NI];
  logic        busy [NI];
  logic        flt  [NI];
  logic [1:0]  dbg  [NI];
`ifdef MMIO_LOAD_STORE_EN
  logic [15:0] io_out [NI];
  logic [15:0] io_in;
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_responder #(
      .DATA_W      (16),
      .ADDR_W      (AW),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .MMIO_ADDR   (16'hFFFF)
    ) u_dut (
      .CLK         (clk),
      .Reset       (rst),
      .Req         (req[g]),
      .MemWrite    (mw[g]),
      .Addr        (addr[g]),
      .WriteData   (wd[g]),
      .ReadData    (rd[g]),
      .Ready       (rdy[g]),
      .Busy        (busy[g]),
      .AddrFault   (flt[g]),
`ifdef MMIO_LOAD_STORE_EN
      .IoOut       (io_out[g]),
      .IoIn        (io_in),
`endif
      .o_dbg_state (dbg[g])
    );
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transaction accepted at edge k touches storage at edge k+W+1 and
  // publishes its response at edge k+W+2; the instance accepts again after that.
  int          m_pend [NI];
  int          m_t    [NI];
  logic        m_we   [NI];
  logic [15:0] m_addr [NI];
  logic [15:0] m_wd   [NI];
  logic [15:0] m_res  [NI];
  logic [15:0] m_mem  [NI][1024];
  logic        e_rdy  [NI];
  logic        e_busy [NI];
  logic        e_flt  [NI];
  logic [15:0] e_rd   [NI];
  logic [15:0] e_io   [NI];

  always @(posedge clk) begin
    for (int d = 0; d < NI; d++) begin
      if (rst) begin
        m_pend[d] = 0;
        e_rdy[d]  = 1'b0;
        e_busy[d] = 1'b0;
        e_flt[d]  = 1'b0;
        e_rd[d]   = 16'h0;
        e_io[d]   = 16'h0;
      end else begin
        e_rdy[d] = 1'b0;
        e_flt[d] = 1'b0;
        if (m_pend[d] != 0) begin
          m_t[d]++;
          if (m_t[d] == wait_of(d) + 1) begin
            m_res[d] = 16'h0;
            if (is_mmio(m_addr[d])) begin
`ifdef MMIO_LOAD_STORE_EN
              if (m_we[d]) e_io[d] = m_wd[d];
              else         m_res[d] = io_in;
`endif
            end else if (in_range(m_addr[d])) begin
              if (m_we[d]) m_mem[d][m_addr[d][AW-1:0]] = m_wd[d];
              else         m_res[d] = m_mem[d][m_addr[d][AW-1:0]];
            end
          end else if (m_t[d] == wait_of(d) + 2) begin
            e_rdy[d] = 1'b1;
            e_flt[d] = !in_range(m_addr[d]) && !is_mmio(m_addr[d]);
            if (!m_we[d]) e_rd[d] = m_res[d];
            m_pend[d] = 0;
          end
        end else if (req[d]) begin
          m_pend[d] = 1;
          m_t[d]    = 0;
          m_we[d]   = mw[d];
          m_addr[d] = addr[d];
          m_wd[d]   = wd[d];
        end
        e_busy[d] = (m_pend[d] != 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < NI; d++) begin
        chk("ready", d, 32'(rdy[d]), 32'(e_rdy[d]));
        chk("busy", d, 32'(busy[d]), 32'(e_busy[d]));
        chk("addr_fault", d, 32'(flt[d]), 32'(e_flt[d]));
        chk("read_data", d, 32'(rd[d]), 32'(e_rd[d]));
`ifdef MMIO_LOAD_STORE_EN
        chk("io_out", d, 32'(io_out[d]), 32'(e_io[d]));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with the instance idle; returns at the negedge where Ready is seen.
  task automatic txn(input int d, input logic w, input logic [15:0] a, input logic [15:0] dat,
                     output int lat);
    req[d] = 1'b1; mw[d] = w; addr[d] = a; wd[d] = dat;
    @(negedge clk);
    req[d]  = 1'b0;
    addr[d] = 16'($urandom);
    wd[d]   = 16'($urandom);
    mw[d]   = 1'($urandom_range(0, 1));
    lat = 0;
    while (!rdy[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) chk("ready_timeout", d, 32'(lat), 32'(wait_of(d) + 2));
  endtask

  // Issue one access and pin its latency, data and fault flag to literals.
  task automatic op(input int d, input logic w, input logic [15:0] a, input logic [15:0] dat,
                    input logic [15:0] exp_rd, input logic exp_flt);
    int lat;
    txn(d, w, a, dat, lat);
    chk(w ? "wr_latency" : "rd_latency", d, 32'(lat), 32'(wait_of(d) + 2));
    if (!w) chk("rd_value", d, 32'(rd[d]), 32'(exp_rd));
    chk("fault_value", d, 32'(flt[d]), 32'(exp_flt));
  endtask

  // ---------------- scoreboard for random phase ----------------
  logic [15:0] exp_q[$];
  logic [15:0] shadow [NI][1024];

  function automatic logic [15:0] pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5) return 16'($urandom_range(0, 15));
    if (r <= 7) return 16'($urandom_range(1008, 1023));
    if (r == 8) return 16'($urandom_range(16'h0400, 16'hFFFE));
    return 16'hFFFF;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int n1;
    int n2;
    logic [15:0] a;
    logic [15:0] v;
    logic        w;

    rst = 1'b1;
    for (int d = 0; d < NI; d++) begin
      req[d] = 1'b0; mw[d] = 1'b0; addr[d] = 16'h0; wd[d] = 16'h0;
    end
`ifdef MMIO_LOAD_STORE_EN
    io_in = 16'h0;
`endif
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int d = 0; d < NI; d++) begin
      chk("reset_ready", d, 32'(rdy[d]), 0);
      chk("reset_busy", d, 32'(busy[d]), 0);
      chk("reset_rd", d, 32'(rd[d]), 0);
      chk("reset_fault", d, 32'(flt[d]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Write then read back with one wait state.
    op(0, 1'b1, 16'h0004, 16'hBEEF, 16'h0000, 1'b0);
    op(0, 1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0);

    // Zero and three wait states.
    op(1, 1'b1, 16'h0000, 16'h0A0A, 16'h0000, 1'b0);
    op(1, 1'b0, 16'h0000, 16'h0000, 16'h0A0A, 1'b0);
    op(2, 1'b1, 16'h0000, 16'h3C3C, 16'h0000, 1'b0);
    op(2, 1'b0, 16'h0000, 16'h0000, 16'h3C3C, 1'b0);

    // Range boundary.
    op(0, 1'b1, 16'h03FF, 16'h7777, 16'h0000, 1'b0);
    op(0, 1'b1, 16'h0400, 16'h1234, 16'h0000, 1'b1);
    op(0, 1'b0, 16'h03FF, 16'h0000, 16'h7777, 1'b0);
    op(0, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1);

    // Req held high, address changed while busy.
    op(0, 1'b1, 16'h0005, 16'h5555, 16'h0000, 1'b0);
    req[0] = 1'b1; mw[0] = 1'b0; addr[0] = 16'h0004;
    @(negedge clk);
    addr[0] = 16'h0005;
    n1 = 0;
    while (!rdy[0] && n1 < 40) begin @(negedge clk); n1++; end
    chk("held_first_lat", 0, 32'(n1), 3);
    chk("held_first_rd", 0, 32'(rd[0]), 32'h0000BEEF);
    n2 = n1;
    @(negedge clk); n2++;
    while (!rdy[0] && n2 < 80) begin @(negedge clk); n2++; end
    req[0] = 1'b0;
    chk("held_spacing", 0, 32'(n2 - n1), 4);
    chk("held_second_rd", 0, 32'(rd[0]), 32'h00005555);

    // Reset during the wait of a write drops it.
    op(2, 1'b1, 16'h0010, 16'h1357, 16'h0000, 1'b0);
    op(2, 1'b0, 16'h0010, 16'h0000, 16'h1357, 1'b0);
    req[2] = 1'b1; mw[2] = 1'b1; addr[2] = 16'h0010; wd[2] = 16'hCAFE;
    @(negedge clk);
    req[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 2, 32'(rdy[2]), 0);
    chk("abort_busy", 2, 32'(busy[2]), 0);
    chk("abort_rd", 2, 32'(rd[2]), 0);
    chk("abort_fault", 2, 32'(flt[2]), 0);
    @(negedge clk);
    op(2, 1'b0, 16'h0010, 16'h0000, 16'h1357, 1'b0);

    // I/O register address.
`ifdef MMIO_LOAD_STORE_EN
    op(0, 1'b1, 16'hFFFF, 16'h00A5, 16'h0000, 1'b0);
    chk("io_out_value", 0, 32'(io_out[0]), 32'h000000A5);
    io_in = 16'h5A5A;
    op(0, 1'b0, 16'hFFFF, 16'h0000, 16'h5A5A, 1'b0);
`else
    op(0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
`endif

    // Random phase: preload a working set, then mixed traffic.
    for (int d = 0; d < NI; d++) begin
      for (int i = 0; i < 32; i++) begin
        a = (i < 16) ? 16'(i) : 16'(1008 + i - 16);
        v = 16'($urandom);
        shadow[d][a[AW-1:0]] = v;
        txn(d, 1'b1, a, v, lat);
      end
      for (int i = 0; i < 150; i++) begin
        a = pick_addr();
        v = 16'($urandom);
        w = 1'($urandom_range(0, 1));
`ifdef MMIO_LOAD_STORE_EN
        io_in = 16'($urandom);
`endif
        if (!w) begin
          if (is_mmio(a)) begin
`ifdef MMIO_LOAD_STORE_EN
            exp_q.push_back(io_in);
`endif
          end else if (in_range(a)) exp_q.push_back(shadow[d][a[AW-1:0]]);
          else exp_q.push_back(16'h0000);
        end else if (in_range(a)) begin
          shadow[d][a[AW-1:0]] = v;
        end
        txn(d, w, a, v, lat);
        chk("rand_latency", d, 32'(lat), 32'(wait_of(d) + 2));
        if (!w && exp_q.size() > 0) chk("rand_rd", d, 32'(rd[d]), 32'(exp_q.pop_front()));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
